// File: rtl/fx_channel_scheduler.sv
// Time-shares one mono effect between the left and right channels of a stereo frame.
// Optional dropped-frame counter is enabled with `define FX_DROP_CNT_EN.
module fx_channel_scheduler #(
    parameter int EFFECT_LATENCY = 2,
    parameter int DROP_CNT_W     = 8
) (
    input  logic                  CLK,
    input  logic                  RESET_N,
    input  logic                  frame_valid,
    input  logic [15:0]           left_in,
    input  logic [15:0]           right_in,
    input  logic                  gain_sw,
    input  logic                  bypass_sw,
    output logic [15:0]           fx_input_frame,
    output logic                  fx_gain,
    input  logic [15:0]           fx_output_frame,
    output logic [15:0]           left_out,
    output logic [15:0]           right_out,
    output logic                  out_valid,
    output logic                  busy,
    output logic [DROP_CNT_W-1:0] drop_count,
    output logic [1:0]            state_dbg
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN_L = 2'd1;
    localparam logic [1:0] RUN_R = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    localparam logic [3:0] LAT = 4'(EFFECT_LATENCY);

    logic [1:0]  state;
    logic [3:0]  cnt;
    logic [15:0] left_lat;
    logic [15:0] right_lat;
    logic [15:0] left_res;
    logic        last;

    // Handshake: frame_valid is a one-cycle strobe with an implied ready of !busy;
    // a strobe that arrives while busy is high is dropped, never queued.
    assign last      = (cnt == LAT);
    assign busy      = (state != IDLE);
    assign out_valid = (state == DONE);
    assign state_dbg = state;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state     <= IDLE;
            cnt       <= '0;
            left_lat  <= '0;
            right_lat <= '0;
            left_res  <= '0;
            left_out  <= '0;
            right_out <= '0;
            fx_gain   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (frame_valid) begin
                        left_lat  <= left_in;
                        right_lat <= right_in;
                        fx_gain   <= gain_sw;
                        cnt       <= '0;
                        // Bypassed frames skip the effect; outputs load on entry to DONE.
                        if (bypass_sw) begin
                            left_out  <= left_in;
                            right_out <= right_in;
                            state     <= DONE;
                        end else begin
                            state <= RUN_L;
                        end
                    end
                end
                RUN_L: begin
                    if (last) begin
                        left_res <= fx_output_frame;
                        cnt      <= '0;
                        state    <= RUN_R;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                RUN_R: begin
                    if (last) begin
                        left_out  <= left_res;
                        right_out <= fx_output_frame;
                        cnt       <= '0;
                        state     <= DONE;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        fx_input_frame = '0;
        case (state)
            RUN_L:   fx_input_frame = left_lat;
            RUN_R:   fx_input_frame = right_lat;
            default: fx_input_frame = '0;
        endcase
    end

`ifdef FX_DROP_CNT_EN
    logic [DROP_CNT_W-1:0] drop_q;

    // Saturates so a long overload never wraps back to a small count.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            drop_q <= '0;
        end else if (frame_valid && busy && (drop_q != '1)) begin
            drop_q <= drop_q + DROP_CNT_W'(1);
        end
    end

    assign drop_count = drop_q;
`else
    assign drop_count = '0;
`endif

endmodule
